// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: consumes BPC bits per clock from the LSB end of
// the latched operands and presents sum, carry-out and overflow after WIDTH/BPC cycles.
module serial_add_sub #(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / BPC;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;

  logic [BPC:0]     c;
  logic [BPC-1:0]   sum_bits;
  logic [WIDTH-1:0] acc_next;

  // One BPC-bit ripple slice; c[BPC-1] is the carry into the slice MSB, which
  // on the final beat is the carry into the operand MSB.
  // NOTE: every bit of c and sum_bits is written on every pass, so no latch is inferred.
  always_comb begin
    c[0] = carry_q;
    for (int i = 0; i < BPC; i++) begin
      sum_bits[i] = a_q[i] ^ b_q[i] ^ c[i];
      c[i+1]      = (a_q[i] & b_q[i]) | (c[i] & (a_q[i] ^ b_q[i]));
    end
  end

  // New sum bits enter at the top so the first slice ends up at the LSB.
  assign acc_next = WIDTH'({sum_bits, acc_q} >> BPC);

  // NOTE: state is updated with non-blocking assignments only; the datapath
  // registers are few and small, so they share the async reset with the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      s       <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          busy <= start;
          if (start) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub ? ~cin : cin;
            acc_q   <= '0;
            cnt_q   <= '0;
            state   <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_q     <= a_q >> BPC;
          b_q     <= b_q >> BPC;
          acc_q   <= acc_next;
          carry_q <= c[BPC];
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            s     <= acc_next;
            cout  <= c[BPC];
            ovf   <= c[BPC] ^ c[BPC-1];
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench for serial_add_sub: an 8-bit/1-bit-per-clock instance and a
// 16-bit/4-bit-per-clock instance checked against an arithmetic reference model.
module tb_serial_add_sub;

  typedef struct {
    int          d;
    int          cyc;
    logic [31:0] s;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start0, cin0, sub0, busy0, done0, cout0, ovf0;
  logic [7:0]  a0, b0, s0;
  logic        start1, cin1, sub1, busy1, done1, cout1, ovf1;
  logic [15:0] a1, b1, s1;

  int          cyc = 0;
  int          n_vec = 0;
  int          n_fail = 0;
  exp_t        exp_q[$];
  int          last_acc[2];
  logic [33:0] held[2];

  serial_add_sub #(.WIDTH(8), .BPC(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0), .cin(cin0), .sub(sub0),
    .busy(busy0), .done(done0), .s(s0), .cout(cout0), .ovf(ovf0)
  );

  serial_add_sub #(.WIDTH(16), .BPC(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1), .sub(sub1),
    .busy(busy1), .done(done1), .s(s1), .cout(cout1), .ovf(ovf1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int width(input int d);
    return (d == 0) ? 8 : 16;
  endfunction

  function automatic int beats(input int d);
    return (d == 0) ? 8 : 4;
  endfunction

  function automatic logic [31:0] mask(input int d);
    return (d == 0) ? 32'h0000_00FF : 32'h0000_FFFF;
  endfunction

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic exp_t model(input int d, input logic [31:0] av, input logic [31:0] bv,
                                 input logic ci, input logic sb);
    exp_t   e;
    longint m    = longint'(1) << width(d);
    longint ua   = longint'(av);
    longint ub   = longint'(bv);
    longint cl   = ci ? 1 : 0;
    longint sa   = (ua >= m / 2) ? ua - m : ua;
    longint sbv  = (ub >= m / 2) ? ub - m : ub;
    longint full;
    longint sres;
    if (!sb) begin
      full   = ua + ub + cl;
      sres   = sa + sbv + cl;
      e.cout = (full >= m);
    end else begin
      full   = ua - ub - cl;
      sres   = sa - sbv - cl;
      e.cout = (full >= 0);
    end
    e.s   = 32'(full & (m - 1));
    e.ovf = (sres < -(m / 2)) || (sres >= m / 2);
    e.d   = d;
    e.cyc = 0;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input int d, input logic st, input logic [31:0] av, input logic [31:0] bv,
                       input logic ci, input logic sb);
    if (d == 0) begin
      start0 = st; a0 = av[7:0]; b0 = bv[7:0]; cin0 = ci; sub0 = sb;
    end else begin
      start1 = st; a1 = av[15:0]; b1 = bv[15:0]; cin1 = ci; sub1 = sb;
    end
  endtask

  task automatic sample(input int d, output logic dn, output logic bz, output logic [33:0] res);
    if (d == 0) begin
      dn = done0; bz = busy0; res = {24'd0, s0, cout0, ovf0};
    end else begin
      dn = done1; bz = busy1; res = {16'd0, s1, cout1, ovf1};
    end
  endtask

  task automatic mon_dut(input int d);
    logic        dn, bz;
    logic [33:0] res;
    int          idx = -1;
    sample(d, dn, bz, res);
    check($sformatf("busy%0d", d), 64'(bz),
          64'(cyc >= last_acc[d] && cyc < last_acc[d] + beats(d)));
    foreach (exp_q[i]) if (idx < 0 && exp_q[i].d == d) idx = i;
    if (dn) begin
      if (idx < 0) begin
        check($sformatf("unexpected done%0d", d), 64'(dn), 64'(0));
      end else begin
        check($sformatf("done cycle%0d", d), 64'(cyc), 64'(exp_q[idx].cyc));
        check($sformatf("result%0d {s,cout,ovf}", d), 64'(res),
              64'({exp_q[idx].s, exp_q[idx].cout, exp_q[idx].ovf}));
        held[d] = {exp_q[idx].s, exp_q[idx].cout, exp_q[idx].ovf};
        exp_q.delete(idx);
      end
    end else begin
      check($sformatf("hold%0d {s,cout,ovf}", d), 64'(res), 64'(held[d]));
      if (idx >= 0 && cyc > exp_q[idx].cyc) begin
        check($sformatf("missing done%0d", d), 64'(dn), 64'(1));
        exp_q.delete(idx);
      end
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst_n) begin
        mon_dut(0);
        mon_dut(1);
      end
    end
  endtask

  task automatic check_reset(input string tag);
    logic        dn, bz;
    logic [33:0] res;
    for (int d = 0; d < 2; d++) begin
      sample(d, dn, bz, res);
      check($sformatf("%s busy%0d", tag, d), 64'(bz), 64'(0));
      check($sformatf("%s done%0d", tag, d), 64'(dn), 64'(0));
      check($sformatf("%s result%0d", tag, d), 64'(res), 64'(0));
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    last_acc[0] = -1000; last_acc[1] = -1000;
    held[0] = '0; held[1] = '0;
  endtask

  // Called just after a negedge; returns at the negedge of the DONE cycle with
  // start low, so a following issue() lands back-to-back. Junk (including
  // start=1) is driven while the operation is in flight.
  task automatic issue(input int d, input logic [31:0] av, input logic [31:0] bv,
                       input logic ci, input logic sb);
    exp_t e = model(d, av & mask(d), bv & mask(d), ci, sb);
    e.cyc = cyc + 1 + beats(d);
    drive(d, 1'b1, av, bv, ci, sb);
    last_acc[d] = cyc + 1;
    exp_q.push_back(e);
    for (int i = 0; i <= beats(d); i++) begin
      @(negedge clk);
      if (i < beats(d))
        drive(d, 1'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom));
      else
        drive(d, 1'b0, av, bv, ci, sb);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b1;
    drive(0, 1'b0, 0, 0, 1'b0, 1'b0);
    drive(1, 1'b0, 0, 0, 1'b0, 1'b0);
    clear_model();
    #2 rst_n = 1'b0;
    #1 check_reset("async reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fork
      monitor();
    join_none

    issue(0, 32'h0F, 32'h01, 1'b0, 1'b0);
    issue(0, 32'h7F, 32'h01, 1'b0, 1'b0);
    issue(0, 32'hFF, 32'h01, 1'b1, 1'b0);
    issue(0, 32'h05, 32'h07, 1'b0, 1'b1);
    issue(0, 32'h80, 32'h01, 1'b0, 1'b1);
    idle(2);
    issue(1, 32'hFFFF, 32'h0001, 1'b0, 1'b0);
    issue(1, 32'h8000, 32'h0001, 1'b1, 1'b1);
    idle(2);

    // Abort mid-run: no result may appear and the previous result is cleared.
    drive(0, 1'b1, 32'h5A, 32'h33, 1'b1, 1'b0);
    last_acc[0] = cyc + 1;
    @(negedge clk);
    drive(0, 1'b0, 0, 0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset("abort reset");
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    issue(0, 32'h21, 32'h12, 1'b0, 1'b0);
    idle(12);

    for (int i = 0; i < 1000; i++) begin
      issue(0, $urandom, $urandom, 1'($urandom), 1'($urandom));
      idle($urandom_range(0, 2));
    end
    for (int i = 0; i < 300; i++) begin
      issue(1, $urandom, $urandom, 1'($urandom), 1'($urandom));
      idle($urandom_range(0, 2));
    end

    for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clk);
    idle(2);
    check("outstanding results", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_add_sub.md
SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits; legal values ≥2.
REQ-002 SHALL have parameter BPC, default 1, bits processed per clock; legal values 1..WIDTH and must divide WIDTH.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  request; sampled on rising clk.
REQ-006 SHALL have port a  input  WIDTH  operand A; sampled with start.
REQ-007 SHALL have port b  input  WIDTH  operand B; sampled with start.
REQ-008 SHALL have port cin  input  1  carry-in (add) or borrow-in (sub); sampled with start.
REQ-009 SHALL have port sub  input  1  0 = add, 1 = subtract; sampled with start.
REQ-010 SHALL have port busy  output  1  high while in RUN.
REQ-011 SHALL have port done  output  1  one-cycle pulse when results are valid.
REQ-012 SHALL have port s  output  WIDTH  sum/difference.
REQ-013 SHALL have port cout  output  1  carry-out from MSB.
REQ-014 SHALL have port ovf  output  1  two's-complement overflow.

Function
REQ-015 SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-016 In IDLE with start=1 at an edge, SHALL load A, B' = sub ? ~b : b, carry = sub ? ~cin : cin, and go to RUN.
REQ-017 Each RUN edge SHALL add the lowest BPC bits of A and B' plus carry via a BPC-bit ripple of full adders, shift the sum bits in MSB-first, and update carry.
REQ-018 SHALL remain in RUN for exactly N = WIDTH/BPC edges, then go to DONE.
REQ-019 done SHALL be 1 in DONE only, i.e. exactly N edges after the accepting start edge; busy SHALL be 1 in RUN only.
REQ-020 On entry to DONE, SHALL update s, cout and ovf; ovf = carry into MSB XOR carry out of MSB.
REQ-021 s, cout and ovf SHALL hold their values until the next DONE entry or reset, and SHALL not change during RUN.
REQ-022 The result SHALL equal (a + b + cin) mod 2^WIDTH for add and (a − b − cin) mod 2^WIDTH for sub.
REQ-023 For sub, cout=1 SHALL mean no borrow occurred.
REQ-024 start during RUN SHALL be ignored; the in-flight operation and latched operands SHALL be unaffected.
REQ-025 DONE with start=1 SHALL load new operands and go directly to RUN (back-to-back); with start=0 it SHALL go to IDLE.
REQ-026 a, b, cin and sub SHALL be don't-care except on the accepting start edge.

Reset
REQ-027 rst_n=0 SHALL immediately (asynchronously) force IDLE, busy=0, done=0, s=0, cout=0, ovf=0, and clear internal operand, shift and carry registers.
REQ-028 Reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow, and the previous result SHALL be lost.
REQ-029 After rst_n deassertion, the first start SHALL be accepted at the first rising edge at which it is sampled high.

Verification (WIDTH=8, BPC=1 unless stated)
REQ-030 Reset: assert rst_n=0 between edges -> all outputs 0 without waiting for a clock edge; busy=0 after release.
REQ-031 Add: a=0x0F, b=0x01, cin=0, sub=0, start one cycle -> busy high 8 cycles, done pulse at edge 8, s=0x10, cout=0, ovf=0; then a=0x7F, b=0x01 -> s=0x80, ovf=1, cout=0; then a=0xFF, b=0x01, cin=1 -> s=0x01, cout=1, ovf=0.
REQ-032 Sub: a=0x05, b=0x07, cin=0, sub=1 -> s=0xFE, cout=0, ovf=0; then a=0x80, b=0x01 -> s=0x7F, ovf=1, cout=1.
REQ-033 Handshake: start held high through RUN with changing a/b -> first result unaffected; start=1 in the DONE cycle -> next done exactly 8 edges later with the new result.
REQ-034 Abort: rst_n pulsed low at RUN cycle 4 -> no done pulse, s=0, next start produces a correct result.
REQ-035 Parameter sweep: WIDTH=16, BPC=4, a=0xFFFF, b=0x0001, cin=0 -> done 4 edges after start, s=0x0000, cout=1; plus 1000 random vectors checked against the REQ-022 reference model.
